traffic_light_ctrl: RTL and testbench

Parametrised two-road intersection controller and the next generation of the fixed 7-state traffic light block. Phase durations and the tick prescaler are parameters, with phase lengths counted in ticks. The block adds a latched pedestrian request served by a dedicated WALK phase, and a flashing-yellow maintenance mode. It sits directly behind the board clock and drives the two lamp groups plus a walk lamp.

---
 rtl/traffic_light_ctrl_if.sv | 20 ++
 rtl/traffic_light_ctrl.sv | 150 +++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_light_ctrl_if.sv
// Lamp/request bundle between the intersection controller and its environment.
interface traffic_light_ctrl_if;
    logic       ped_req;
    logic       flash;
    logic [2:0] light1;
    logic [2:0] light2;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    modport master (
        output ped_req, flash,
        input  light1, light2, walk, ped_ack, phase
    );

    modport slave (
        input  ped_req, flash,
        output light1, light2, walk, ped_ack, phase
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller with pedestrian WALK phase and flashing-yellow maintenance mode.
module traffic_light_ctrl #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned GREEN_T  = 5,
    parameter int unsigned YELLOW_T = 2,
    parameter int unsigned ALLRED_T = 1,
    parameter int unsigned WALK_T   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_light_ctrl_if.slave  bus
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned PW = 16;

    typedef enum logic [2:0] {
        RED_A = 3'd0,
        A_GRN = 3'd1,
        A_YEL = 3'd2,
        RED_B = 3'd3,
        B_GRN = 3'd4,
        B_YEL = 3'd5,
        WALK  = 3'd6,
        FLASH = 3'd7
    } state_t;

    state_t        state, state_nx;
    logic [TW-1:0] tick_cnt, tick_cnt_nx;
    logic [PW-1:0] phase_cnt, phase_cnt_nx;
    logic [PW-1:0] dur;
    logic          tick;
    logic          ped_pending, ped_pending_nx;
    logic          blink, blink_nx;
    logic [2:0]    light1, light1_nx;
    logic [2:0]    light2, light2_nx;
    logic          walk, walk_nx;
    logic          ped_ack, ped_ack_nx;

    // Road A lamp decode {green, yellow, red}
    function automatic logic [2:0] lamp_a(input state_t s, input logic b);
        case (s)
            A_GRN:   return 3'b100;
            A_YEL:   return 3'b010;
            FLASH:   return {1'b0, b, 1'b0};
            default: return 3'b001;
        endcase
    endfunction

    // Road B lamp decode {green, yellow, red}
    function automatic logic [2:0] lamp_b(input state_t s, input logic b);
        case (s)
            B_GRN:   return 3'b100;
            B_YEL:   return 3'b010;
            FLASH:   return {1'b0, b, 1'b0};
            default: return 3'b001;
        endcase
    endfunction

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RED_A;
            tick_cnt    <= '0;
            phase_cnt   <= '0;
            ped_pending <= 1'b0;
            blink       <= 1'b1;
            light1      <= 3'b001;
            light2      <= 3'b001;
            walk        <= 1'b0;
            ped_ack     <= 1'b0;
        end else begin
            state       <= state_nx;
            tick_cnt    <= tick_cnt_nx;
            phase_cnt   <= phase_cnt_nx;
            ped_pending <= ped_pending_nx;
            blink       <= blink_nx;
            light1      <= light1_nx;
            light2      <= light2_nx;
            walk        <= walk_nx;
            ped_ack     <= ped_ack_nx;
        end
    end

    // Next-state, counter updates and output decode from the next state
    always_comb begin
        state_nx       = state;
        tick_cnt_nx    = tick ? '0 : tick_cnt + 1'b1;
        phase_cnt_nx   = phase_cnt;
        blink_nx       = blink;
        ped_pending_nx = ped_pending | bus.ped_req;

        case (state)
            RED_A, RED_B: dur = PW'(ALLRED_T);
            A_GRN, B_GRN: dur = PW'(GREEN_T);
            A_YEL, B_YEL: dur = PW'(YELLOW_T);
            WALK:         dur = PW'(WALK_T);
            default:      dur = PW'(1);
        endcase

        if (state != FLASH && bus.flash) begin
            state_nx     = FLASH;
            tick_cnt_nx  = '0;
            phase_cnt_nx = '0;
            blink_nx     = 1'b1;
        end else if (state == FLASH) begin
            if (!bus.flash) begin
                state_nx     = RED_A;
                tick_cnt_nx  = '0;
                phase_cnt_nx = '0;
            end else if (tick) begin
                blink_nx = ~blink;
            end
        end else if (tick) begin
            if (phase_cnt == dur - PW'(1)) begin
                phase_cnt_nx = '0;
                case (state)
                    RED_A:   state_nx = A_GRN;
                    A_GRN:   state_nx = A_YEL;
                    A_YEL:   state_nx = RED_B;
                    RED_B:   state_nx = B_GRN;
                    B_GRN:   state_nx = B_YEL;
                    B_YEL:   state_nx = ped_pending ? WALK : RED_A;
                    default: state_nx = RED_A;
                endcase
            end else begin
                phase_cnt_nx = phase_cnt + PW'(1);
            end
        end

        // Entering WALK consumes the request; a same-cycle request is dropped
        ped_ack_nx = (state_nx == WALK) && (state != WALK);
        if (ped_ack_nx) begin
            ped_pending_nx = 1'b0;
        end

        light1_nx = lamp_a(state_nx, blink_nx);
        light2_nx = lamp_b(state_nx, blink_nx);
        walk_nx   = (state_nx == WALK);
    end

    assign bus.light1  = light1;
    assign bus.light2  = light2;
    assign bus.walk    = walk;
    assign bus.ped_ack = ped_ack;
    assign bus.phase   = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench: per-cycle scoreboard from a cycle-count model, vector table, corner sequences.
module tb_traffic_light_ctrl;

    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst;
    logic rst1;
    always #5 clk = ~clk;

    traffic_light_ctrl_if bus();
    traffic_light_ctrl_if bus1();

    traffic_light_ctrl #(.TICK_DIV(4), .GREEN_T(3), .YELLOW_T(1), .ALLRED_T(1), .WALK_T(2)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    traffic_light_ctrl #(.TICK_DIV(1), .GREEN_T(1), .YELLOW_T(1), .ALLRED_T(1), .WALK_T(1)) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1)
    );

    typedef struct {
        logic [2:0] ph;
        logic [2:0] l1;
        logic [2:0] l2;
        logic       walk;
        logic       ack;
    } exp_t;

    typedef struct {
        logic       r;
        logic       p;
        logic       f;
        int         n;
        logic [2:0] ph;
        logic [2:0] l1;
        logic [2:0] l2;
        logic       walk;
    } vec_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   k1 = 0;
    int   cnt_walk = 0;
    int   cnt_ack = 0;
    bit   chk_en = 0;

    // bench model: phase held for a number of clk cycles
    int m_ph = 0, m_rem = 0, m_fcnt = 0;
    bit m_pend = 0, m_blink = 1, m_ack = 0;

    function automatic int dwell(input int ph);
        case (ph)
            1, 4:    return 3 * TD;
            6:       return 2 * TD;
            default: return 1 * TD;
        endcase
    endfunction

    function automatic logic [2:0] exp_lamp(input int ph, input bit b, input bit road_b);
        if (ph == 7) return {1'b0, b, 1'b0};
        if (!road_b && ph == 1) return 3'b100;
        if (!road_b && ph == 2) return 3'b010;
        if (road_b && ph == 4) return 3'b100;
        if (road_b && ph == 5) return 3'b010;
        return 3'b001;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic model_step(input logic r, input logic p, input logic f);
        int old = m_ph;
        if (r) begin
            m_ph = 0; m_rem = dwell(0); m_pend = 0; m_blink = 1; m_ack = 0; m_fcnt = 0;
            return;
        end
        if (m_ph != 7 && f) begin
            m_ph = 7; m_fcnt = 0; m_blink = 1;
        end else if (m_ph == 7) begin
            if (!f) begin
                m_ph = 0; m_rem = dwell(0);
            end else if (m_fcnt == TD - 1) begin
                m_fcnt = 0; m_blink = ~m_blink;
            end else begin
                m_fcnt++;
            end
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                case (m_ph)
                    5:       m_ph = m_pend ? 6 : 0;
                    6:       m_ph = 0;
                    default: m_ph = m_ph + 1;
                endcase
                m_rem = dwell(m_ph);
            end
        end
        m_ack  = (m_ph == 6) && (old != 6);
        m_pend = m_ack ? 1'b0 : (m_pend | p);
    endtask

    // One clock: drive, push model expectation, sample after the edge, compare
    task automatic step(input logic r, input logic p, input logic f);
        exp_t e;
        rst = r; bus.ped_req = p; bus.flash = f;
        model_step(r, p, f);
        e.ph = 3'(m_ph);
        e.l1 = exp_lamp(m_ph, m_blink, 1'b0);
        e.l2 = exp_lamp(m_ph, m_blink, 1'b1);
        e.walk = (m_ph == 6);
        e.ack = m_ack;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        chk_en = 1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 16'd1, 16'd0);
        end else begin
            e = sb_q.pop_front();
            check("sb_outputs",
                  {3'b0, bus.phase, bus.light1, bus.light2, bus.walk, bus.ped_ack},
                  {3'b0, e.ph, e.l1, e.l2, e.walk, e.ack});
        end
        if (bus.walk === 1'b1) cnt_walk++;
        if (bus.ped_ack === 1'b1) cnt_ack++;
        if (rst1) begin
            rst1 = 0; k1 = 0;
        end else begin
            k1++;
        end
        check("tick1_phase", 16'(bus1.phase), 16'(k1 % 6));
    endtask

    task automatic run(input int n, input logic p, input logic f);
        for (int i = 0; i < n; i++) step(1'b0, p, f);
    endtask

    // Safety invariant on both instances: no two greens, no green with walk
    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if ((bus.light1[2] && bus.light2[2]) || ((bus.light1[2] || bus.light2[2]) && bus.walk) ||
                (bus1.light1[2] && bus1.light2[2]) || ((bus1.light1[2] || bus1.light2[2]) && bus1.walk)) begin
                n_bad++;
                $display("FAIL safety: l1=%b l2=%b w=%b / l1=%b l2=%b w=%b required no conflicting green",
                         bus.light1, bus.light2, bus.walk, bus1.light1, bus1.light2, bus1.walk);
            end
        end
    end

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0,  1, 3'd0, 3'b001, 3'b001, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0,  3, 3'd0, 3'b001, 3'b001, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b0,  1, 3'd1, 3'b100, 3'b001, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 11, 3'd1, 3'b100, 3'b001, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0,  1, 3'd2, 3'b010, 3'b001, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0,  4, 3'd3, 3'b001, 3'b001, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0,  4, 3'd4, 3'b001, 3'b100, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 12, 3'd5, 3'b001, 3'b010, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0,  4, 3'd0, 3'b001, 3'b001, 1'b0};

        rst = 1'b1; rst1 = 1'b1; bus.ped_req = 1'b0; bus.flash = 1'b0;
        bus1.ped_req = 1'b0; bus1.flash = 1'b0;

        // Reset and free-run period from the vector table
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < tbl[i].n; j++) step(tbl[i].r, tbl[i].p, tbl[i].f);
            check($sformatf("tbl%0d", i),
                  {6'b0, bus.phase, bus.light1, bus.light2, bus.walk},
                  {6'b0, tbl[i].ph, tbl[i].l1, tbl[i].l2, tbl[i].walk});
        end

        // One-cycle request in A_GRN: single 8-cycle WALK, one ack
        step(1'b1, 1'b0, 1'b0);
        run(9, 1'b0, 1'b0);
        cnt_walk = 0; cnt_ack = 0;
        step(1'b0, 1'b1, 1'b0);
        run(100, 1'b0, 1'b0);
        check("pulse_walk_cycles", 16'(cnt_walk), 16'd8);
        check("pulse_ack_count", 16'(cnt_ack), 16'd1);

        // Request held through WALK entry: served twice
        step(1'b1, 1'b0, 1'b0);
        cnt_walk = 0; cnt_ack = 0;
        run(45, 1'b1, 1'b0);
        run(60, 1'b0, 1'b0);
        check("held_walk_cycles", 16'(cnt_walk), 16'd16);
        check("held_ack_count", 16'(cnt_ack), 16'd2);

        // Flash entered from B_GRN
        step(1'b1, 1'b0, 1'b0);
        run(26, 1'b0, 1'b0);
        check("pre_flash_bgrn", 16'(bus.phase), 16'd4);
        step(1'b0, 1'b0, 1'b1);
        check("flash_entry", {7'b0, bus.phase, bus.light1, bus.light2}, {7'b0, 3'd7, 3'b010, 3'b010});
        run(3, 1'b0, 1'b1);
        check("flash_blink_on", {10'b0, bus.light1, bus.light2}, {10'b0, 3'b010, 3'b010});
        run(1, 1'b0, 1'b1);
        check("flash_blink_off", {10'b0, bus.light1, bus.light2}, {10'b0, 3'b000, 3'b000});
        run(15, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("flash_exit", {10'b0, bus.phase, bus.light1}, {10'b0, 3'd0, 3'b001});
        run(3, 1'b0, 1'b0);
        check("flash_exit_reda_hold", 16'(bus.phase), 16'd0);
        run(1, 1'b0, 1'b0);
        check("flash_exit_agrn", 16'(bus.phase), 16'd1);

        // Reset mid-WALK with a fresh pending request
        step(1'b1, 1'b0, 1'b0);
        run(10, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        run(31, 1'b0, 1'b0);
        check("in_walk", {15'b0, bus.walk}, 16'd1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("rst_mid_walk",
              {4'b0, bus.phase, bus.light1, bus.light2, bus.walk, bus.ped_ack},
              {4'b0, 3'd0, 3'b001, 3'b001, 1'b0, 1'b0});
        cnt_walk = 0;
        run(40, 1'b0, 1'b0);
        check("no_walk_after_rst", 16'(cnt_walk), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
